// File: rtl/ucsbece154b_hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, load result select, FSM states.
package ucsbece154b_hazard_unit_pkg;

    localparam logic [1:0] forward_ex  = 2'b00;
    localparam logic [1:0] forward_wb  = 2'b01;
    localparam logic [1:0] forward_mem = 2'b10;

    localparam logic [1:0] mux_result_mem = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats a same-cycle increment.
module ucsbece154b_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ucsbece154b_hazard_unit.sv
// Pipeline hazard unit: forwarding selects, stall/flush priority, memory-wait freeze
// with timeout monitor, and saturating hazard counters.
import ucsbece154b_hazard_unit_pkg::*;

module ucsbece154b_hazard_unit #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned ZERO_REG_EN = 1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] Rs1D_i,
    input  logic [REG_ADDR_W-1:0] Rs2D_i,
    input  logic                  UsesRs1D_i,
    input  logic                  UsesRs2D_i,
    input  logic [REG_ADDR_W-1:0] Rs1E_i,
    input  logic [REG_ADDR_W-1:0] Rs2E_i,
    input  logic [REG_ADDR_W-1:0] RdE_i,
    input  logic [REG_ADDR_W-1:0] RdM_i,
    input  logic [REG_ADDR_W-1:0] RdW_i,
    input  logic                  RegWriteE_i,
    input  logic                  RegWriteM_i,
    input  logic                  RegWriteW_i,
    input  logic [1:0]            ResultSrcE_i,
    input  logic                  PCSrcE_i,
    input  logic                  MemReqM_i,
    input  logic                  MemReadyM_i,
    input  logic                  CntClr_i,
    output logic                  StallF_o,
    output logic                  StallD_o,
    output logic                  StallE_o,
    output logic                  StallM_o,
    output logic                  FlushD_o,
    output logic                  FlushE_o,
    output logic                  FlushW_o,
    output logic [1:0]            ForwardAE_o,
    output logic [1:0]            ForwardBE_o,
    output logic                  MemTimeout_o,
    output logic [CNT_W-1:0]      LoadUseCnt_o,
    output logic [CNT_W-1:0]      RedirectCnt_o,
    output logic [CNT_W-1:0]      MemWaitCnt_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    function automatic logic nz(input logic [REG_ADDR_W-1:0] r);
        return (ZERO_REG_EN == 0) || (r != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (RegWriteM_i && nz(rs) && (RdM_i == rs)) begin
            return forward_mem;
        end else if (RegWriteW_i && nz(rs) && (RdW_i == rs)) begin
            return forward_wb;
        end
        return forward_ex;
    endfunction

    logic              w_mem_stall;
    logic              w_lw_stall;
    logic              w_redirect;
    logic              w_load_use;
    hz_state_e         r_state;
    hz_state_e         w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_timeout;

    assign w_mem_stall = MemReqM_i && !MemReadyM_i;
    assign w_lw_stall  = (ResultSrcE_i == mux_result_mem) && RegWriteE_i && nz(RdE_i)
                       && ((UsesRs1D_i && (Rs1D_i == RdE_i)) || (UsesRs2D_i && (Rs2D_i == RdE_i)));
    assign w_redirect  = !w_mem_stall && PCSrcE_i;
    assign w_load_use  = !w_mem_stall && !PCSrcE_i && w_lw_stall;

    assign ForwardAE_o = fwd_sel(Rs1E_i);
    assign ForwardBE_o = fwd_sel(Rs2E_i);

    // A memory wait freezes everything and defers redirect and load-use handling.
    always_comb begin
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        FlushW_o = 1'b0;
        if (w_mem_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
        end else if (PCSrcE_i) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else if (w_lw_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else begin
                    w_wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait != WAIT_W'(MEM_TIMEOUT)) begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end else begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Sticky flag set on the edge the wait count lands on the timeout value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout <= 1'b0;
        end else if (CntClr_i) begin
            r_timeout <= 1'b0;
        end else if (w_mem_stall && (w_wait_nxt == WAIT_W'(MEM_TIMEOUT))) begin
            r_timeout <= 1'b1;
        end
    end

    assign MemTimeout_o = r_timeout;

    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt_load_use (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_load_use),
        .i_clr   (CntClr_i),
        .o_q     (LoadUseCnt_o)
    );

    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt_redirect (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_redirect),
        .i_clr   (CntClr_i),
        .o_q     (RedirectCnt_o)
    );

    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt_mem_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_mem_stall),
        .i_clr   (CntClr_i),
        .o_q     (MemWaitCnt_o)
    );

endmodule

// File: tb/tb_ucsbece154b_hazard_unit.sv
// Directed bench for the hazard unit with a short timeout and narrow counters.
import ucsbece154b_hazard_unit_pkg::*;

module tb_ucsbece154b_hazard_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [RW-1:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
    logic          UsesRs1D_i, UsesRs2D_i;
    logic          RegWriteE_i, RegWriteM_i, RegWriteW_i;
    logic [1:0]    ResultSrcE_i;
    logic          PCSrcE_i, MemReqM_i, MemReadyM_i, CntClr_i;
    logic          StallF_o, StallD_o, StallE_o, StallM_o;
    logic          FlushD_o, FlushE_o, FlushW_o;
    logic [1:0]    ForwardAE_o, ForwardBE_o;
    logic          MemTimeout_o;
    logic [CW-1:0] LoadUseCnt_o, RedirectCnt_o, MemWaitCnt_o;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [6:0]    w_ctl;
    assign w_ctl = {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ucsbece154b_hazard_unit #(
        .REG_ADDR_W  (RW),
        .ZERO_REG_EN (1),
        .MEM_TIMEOUT (4),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .Rs1D_i        (Rs1D_i),
        .Rs2D_i        (Rs2D_i),
        .UsesRs1D_i    (UsesRs1D_i),
        .UsesRs2D_i    (UsesRs2D_i),
        .Rs1E_i        (Rs1E_i),
        .Rs2E_i        (Rs2E_i),
        .RdE_i         (RdE_i),
        .RdM_i         (RdM_i),
        .RdW_i         (RdW_i),
        .RegWriteE_i   (RegWriteE_i),
        .RegWriteM_i   (RegWriteM_i),
        .RegWriteW_i   (RegWriteW_i),
        .ResultSrcE_i  (ResultSrcE_i),
        .PCSrcE_i      (PCSrcE_i),
        .MemReqM_i     (MemReqM_i),
        .MemReadyM_i   (MemReadyM_i),
        .CntClr_i      (CntClr_i),
        .StallF_o      (StallF_o),
        .StallD_o      (StallD_o),
        .StallE_o      (StallE_o),
        .StallM_o      (StallM_o),
        .FlushD_o      (FlushD_o),
        .FlushE_o      (FlushE_o),
        .FlushW_o      (FlushW_o),
        .ForwardAE_o   (ForwardAE_o),
        .ForwardBE_o   (ForwardBE_o),
        .MemTimeout_o  (MemTimeout_o),
        .LoadUseCnt_o  (LoadUseCnt_o),
        .RedirectCnt_o (RedirectCnt_o),
        .MemWaitCnt_o  (MemWaitCnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D_i = '0; Rs2D_i = '0; Rs1E_i = '0; Rs2E_i = '0;
        RdE_i = '0; RdM_i = '0; RdW_i = '0;
        UsesRs1D_i = 1'b0; UsesRs2D_i = 1'b0;
        RegWriteE_i = 1'b0; RegWriteM_i = 1'b0; RegWriteW_i = 1'b0;
        ResultSrcE_i = 2'b00; PCSrcE_i = 1'b0;
        MemReqM_i = 1'b0; MemReadyM_i = 1'b0; CntClr_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lw x5 in E, D reads x5 through Rs1
    task automatic load_in_e();
        idle_inputs();
        ResultSrcE_i = 2'b01; RegWriteE_i = 1'b1; RdE_i = 5'd5;
        Rs1D_i = 5'd5; Rs2D_i = 5'd1; UsesRs1D_i = 1'b1; UsesRs2D_i = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("rst_ctl", 32'(w_ctl), 32'h0);
        check("rst_fwd", 32'({ForwardAE_o, ForwardBE_o}), 32'h0);
        check("rst_cnt", 32'({LoadUseCnt_o, RedirectCnt_o, MemWaitCnt_o}), 32'h0);
        check("rst_tmo", 32'(MemTimeout_o), 32'h0);
        check("rst_state", 32'(dut.r_state), 32'(RUN));
        step(); step();
        reset_n = 1'b1;
        step();

        // load-use stall on Rs1
        load_in_e(); #1;
        check("lu_rs1_ctl", 32'(w_ctl), 32'b1100010);
        step();
        check("lu_cnt1", 32'(LoadUseCnt_o), 32'd1);
        // load-use stall on Rs2 only
        load_in_e(); Rs1D_i = 5'd1; Rs2D_i = 5'd5; #1;
        check("lu_rs2_ctl", 32'(w_ctl), 32'b1100010);
        step();
        check("lu_cnt2", 32'(LoadUseCnt_o), 32'd2);
        // lui in D reads nothing
        load_in_e(); UsesRs1D_i = 1'b0; UsesRs2D_i = 1'b0; #1;
        check("lui_ctl", 32'(w_ctl), 32'h0);
        step();
        check("lui_cnt", 32'(LoadUseCnt_o), 32'd2);
        // load into x0 is never a hazard
        load_in_e(); RdE_i = 5'd0; Rs1D_i = 5'd0; #1;
        check("x0_ctl", 32'(w_ctl), 32'h0);
        step();

        // forwarding
        idle_inputs();
        RegWriteM_i = 1'b1; RegWriteW_i = 1'b1; RdM_i = 5'd7; RdW_i = 5'd7; Rs1E_i = 5'd7; #1;
        check("fwdA_mem_prio", 32'(ForwardAE_o), 32'(2'b10));
        check("fwdB_none", 32'(ForwardBE_o), 32'(2'b00));
        idle_inputs();
        RegWriteM_i = 1'b1; RdM_i = 5'd0; Rs1E_i = 5'd0; #1;
        check("fwdA_x0", 32'(ForwardAE_o), 32'(2'b00));
        idle_inputs();
        RegWriteM_i = 1'b1; RdM_i = 5'd9; RegWriteW_i = 1'b1; RdW_i = 5'd3; Rs2E_i = 5'd3; Rs1E_i = 5'd9; #1;
        check("fwdB_wb", 32'(ForwardBE_o), 32'(2'b01));
        check("fwdA_mem", 32'(ForwardAE_o), 32'(2'b10));
        idle_inputs();
        RegWriteM_i = 1'b0; RdM_i = 5'd4; RegWriteW_i = 1'b1; RdW_i = 5'd4; Rs1E_i = 5'd4; #1;
        check("fwdA_wb_nowrM", 32'(ForwardAE_o), 32'(2'b01));
        step();

        // redirect outranks load-use
        load_in_e(); PCSrcE_i = 1'b1; #1;
        check("redir_ctl", 32'(w_ctl), 32'b0000110);
        step();
        check("redir_cnt", 32'(RedirectCnt_o), 32'd1);
        check("redir_lu_cnt", 32'(LoadUseCnt_o), 32'd2);

        // 3-cycle memory wait; first cycle also has redirect + load-use pending
        for (int i = 0; i < 3; i++) begin
            load_in_e(); PCSrcE_i = (i == 0); MemReqM_i = 1'b1; MemReadyM_i = 1'b0; #1;
            check($sformatf("mw_ctl%0d", i), 32'(w_ctl), 32'b1111001);
            step();
            check($sformatf("mw_state%0d", i), 32'(dut.r_state), 32'(MEM_WAIT));
        end
        check("mw_redir_cnt", 32'(RedirectCnt_o), 32'd1);
        check("mw_lu_cnt", 32'(LoadUseCnt_o), 32'd2);
        idle_inputs(); MemReqM_i = 1'b1; MemReadyM_i = 1'b1; #1;
        check("mw_done_ctl", 32'(w_ctl), 32'h0);
        step();
        check("mw_cnt", 32'(MemWaitCnt_o), 32'd3);
        check("mw_state_run", 32'(dut.r_state), 32'(RUN));
        check("mw_tmo", 32'(MemTimeout_o), 32'd0);

        // 6-cycle wait with timeout of 4
        for (int k = 1; k <= 6; k++) begin
            idle_inputs(); MemReqM_i = 1'b1; step();
            check($sformatf("tmo_k%0d", k), 32'(MemTimeout_o), 32'(k >= 4));
            check($sformatf("tmo_cnt%0d", k), 32'(MemWaitCnt_o), 32'(3 + k));
        end
        idle_inputs(); step();
        check("tmo_sticky", 32'(MemTimeout_o), 32'd1);
        check("tmo_state", 32'(dut.r_state), 32'(RUN));
        // clear wins over a same-cycle load-use increment
        load_in_e(); CntClr_i = 1'b1; step();
        check("clr_tmo", 32'(MemTimeout_o), 32'd0);
        check("clr_cnt", 32'({LoadUseCnt_o, RedirectCnt_o, MemWaitCnt_o}), 32'h0);

        // saturation at 15
        for (int k = 0; k < 20; k++) begin
            load_in_e(); step();
        end
        check("lu_sat", 32'(LoadUseCnt_o), 32'd15);

        // async reset mid-wait
        idle_inputs(); PCSrcE_i = 1'b1; step();
        MemReqM_i = 1'b1; PCSrcE_i = 1'b0; step(); step();
        check("pre_rst_state", 32'(dut.r_state), 32'(MEM_WAIT));
        check("pre_rst_mw", 32'(MemWaitCnt_o), 32'd2);
        #2 reset_n = 1'b0; #1;
        check("mid_rst_state", 32'(dut.r_state), 32'(RUN));
        check("mid_rst_cnt", 32'({LoadUseCnt_o, RedirectCnt_o, MemWaitCnt_o}), 32'h0);
        check("mid_rst_tmo", 32'(MemTimeout_o), 32'd0);
        idle_inputs(); step();
        reset_n = 1'b1; step();
        check("post_rst_ctl", 32'(w_ctl), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
